// File: rtl/vsd_timer_pkg.sv
// Shared register map and bit positions for the vsd_timer peripheral.
// Offsets are word indices into addr[3:2].
package vsd_timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_LOAD   = 2'd1;
  localparam logic [1:0] ADDR_VALUE  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int unsigned CTRL_EN        = 0;
  localparam int unsigned CTRL_MODE      = 1;
  localparam int unsigned STATUS_TIMEOUT = 0;

endpackage

// File: rtl/vsd_timer_counter.sv
// Down-counter core: holds VALUE, reloads on start, decrements while enabled.
// expire_o is combinational and marks the edge on which VALUE<=1 is consumed.
module vsd_timer_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             start_i,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] load_i,
  output logic [WIDTH-1:0] value_o,
  output logic             expire_o
);

  logic [WIDTH-1:0] value_q, value_d;

  always_comb begin
    value_d  = value_q;
    expire_o = 1'b0;
    if (start_i) begin
      value_d = load_i;
    end else if (en_i) begin
      if (value_q > WIDTH'(1)) begin
        value_d = value_q - WIDTH'(1);
      end else begin
        // VALUE of 0 also expires, so LOAD=0 fires on the first enabled cycle
        expire_o = 1'b1;
        value_d  = mode_i ? load_i : '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/vsd_timer.sv
// Memory-mapped down-counting timer with one-shot/periodic modes and a sticky timeout flag.
// Register decode and the zero-latency read mux live here; counting lives in vsd_timer_counter.
module vsd_timer
  import vsd_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        timeout
);

  logic             en_q, en_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic             timeout_q, timeout_d;

  logic             wr;
  logic             ctrl_wr, load_wr, status_wr;
  logic             start;
  logic [WIDTH-1:0] value;
  logic             expire;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

  assign wr        = sel & we;
  assign ctrl_wr   = wr & (addr[3:2] == ADDR_CTRL);
  assign load_wr   = wr & (addr[3:2] == ADDR_LOAD);
  assign status_wr = wr & (addr[3:2] == ADDR_STATUS);
  assign start     = ctrl_wr & wdata[CTRL_EN];

  vsd_timer_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk_i    (clk),
    .resetn_i (resetn),
    .start_i  (start),
    .en_i     (en_q & ~ctrl_wr),
    .mode_i   (mode_q),
    .load_i   (load_q),
    .value_o  (value),
    .expire_o (expire)
  );

  always_comb begin
    en_d      = en_q;
    mode_d    = mode_q;
    load_d    = load_q;
    timeout_d = timeout_q;

    if (ctrl_wr) begin
      en_d   = wdata[CTRL_EN];
      mode_d = wdata[CTRL_MODE];
    end else if (expire && !mode_q) begin
      en_d = 1'b0;
    end

    if (load_wr) begin
      load_d = wdata[WIDTH-1:0];
    end

    // Restart clears; a fresh expiry wins over a same-cycle W1C
    if (start) begin
      timeout_d = 1'b0;
    end else if (expire) begin
      timeout_d = 1'b1;
    end else if (status_wr && wdata[STATUS_TIMEOUT]) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en_q      <= 1'b0;
      mode_q    <= 1'b0;
      load_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      en_q      <= en_d;
      mode_q    <= mode_d;
      load_q    <= load_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel && !we) begin
      case (addr[3:2])
        ADDR_CTRL: begin
          rdata[CTRL_EN]   = en_q;
          rdata[CTRL_MODE] = mode_q;
        end
        ADDR_LOAD:   rdata = 32'(load_q);
        ADDR_VALUE:  rdata = 32'(value);
        ADDR_STATUS: rdata[STATUS_TIMEOUT] = timeout_q;
        default:     rdata = '0;
      endcase
    end
  end

  assign timeout = timeout_q;

endmodule

// File: tb/tb_vsd_timer.sv
// Directed bench for vsd_timer: all bus activity is aligned to falling edges,
// so each write consumes exactly one rising edge and reads consume none.
module tb_vsd_timer;

  logic        clk;
  logic        resetn;
  logic        sel;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        timeout;

  int checks;
  int errors;

  vsd_timer dut (
    .clk     (clk),
    .resetn  (resetn),
    .sel     (sel),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    sel   = 1'b1;
    we    = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    sel   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    sel  = 1'b1;
    we   = 1'b0;
    addr = a;
    #1;
    d    = rdata;
    sel  = 1'b0;
    addr = '0;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    int          per_vals[7];
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    sel    = 1'b0;
    we     = 1'b0;
    addr   = '0;
    wdata  = '0;
    per_vals = '{5, 4, 3, 2, 1, 5, 4};

    // Reset state
    step(2);
    chk("rst_rdata_idle", rdata, 32'h0);
    chk("rst_timeout", {31'b0, timeout}, 32'h0);
    resetn = 1'b1;
    step(1);
    rd(32'h0, d);  chk("rst_ctrl", d, 32'h0);
    rd(32'h4, d);  chk("rst_load", d, 32'h0);
    rd(32'h8, d);  chk("rst_value", d, 32'h0);
    rd(32'hC, d);  chk("rst_status", d, 32'h0);

    // One-shot LOAD=10
    wr(32'h4, 32'd10);
    wr(32'h0, 32'h1);
    for (int i = 10; i >= 1; i--) begin
      rd(32'h8, d);
      chk($sformatf("os_value_%0d", i), d, 32'(i));
      chk($sformatf("os_to_pre_%0d", i), {31'b0, timeout}, 32'h0);
      step(1);
    end
    rd(32'h8, d);  chk("os_value_end", d, 32'h0);
    chk("os_timeout", {31'b0, timeout}, 32'h1);
    step(3);
    rd(32'h8, d);  chk("os_value_hold", d, 32'h0);
    rd(32'hC, d);  chk("os_status", d, 32'h1);
    rd(32'h0, d);  chk("os_ctrl_autoclr", d, 32'h0);

    // Periodic LOAD=5; the start clears the old TIMEOUT
    wr(32'h4, 32'd5);
    wr(32'h0, 32'h3);
    chk("per_start_clr", {31'b0, timeout}, 32'h0);
    for (int i = 0; i < 7; i++) begin
      rd(32'h8, d);
      chk($sformatf("per_value_%0d", i), d, 32'(per_vals[i]));
      chk($sformatf("per_to_%0d", i), {31'b0, timeout}, (i >= 5) ? 32'h1 : 32'h0);
      step(1);
    end
    rd(32'h0, d);  chk("per_ctrl", d, 32'h3);

    // STATUS writes: 0 has no effect, 1 clears, and expiry beats W1C
    wr(32'hC, 32'h0);
    chk("w1c_zero_noeff", {31'b0, timeout}, 32'h1);
    rd(32'h8, d);  chk("w1c_val_2", d, 32'd2);
    wr(32'hC, 32'h1);
    chk("w1c_clear", {31'b0, timeout}, 32'h0);
    rd(32'h8, d);  chk("w1c_val_1", d, 32'd1);
    wr(32'hC, 32'h1);
    chk("w1c_vs_expiry", {31'b0, timeout}, 32'h1);
    rd(32'h8, d);  chk("w1c_reload", d, 32'd5);

    // Pause at 12 and restart with a new LOAD
    wr(32'h4, 32'd20);
    wr(32'h0, 32'h1);
    step(8);
    rd(32'h8, d);  chk("pause_at12", d, 32'd12);
    wr(32'h0, 32'h0);
    rd(32'h8, d);  chk("pause_halt", d, 32'd12);
    step(3);
    rd(32'h8, d);  chk("pause_hold", d, 32'd12);
    rd(32'h0, d);  chk("pause_ctrl", d, 32'h0);
    wr(32'h4, 32'd7);
    rd(32'h8, d);  chk("pause_load_noeff", d, 32'd12);
    wr(32'h0, 32'h1);
    rd(32'h8, d);  chk("restart_7", d, 32'd7);
    step(1);
    rd(32'h8, d);  chk("restart_6", d, 32'd6);

    // Async reset mid-count
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_timeout", {31'b0, timeout}, 32'h0);
    step(1);
    rd(32'h8, d);  chk("arst_value", d, 32'h0);
    rd(32'h4, d);  chk("arst_load", d, 32'h0);
    rd(32'h0, d);  chk("arst_ctrl", d, 32'h0);
    resetn = 1'b1;
    step(3);
    rd(32'h8, d);  chk("idle_value", d, 32'h0);
    rd(32'h0, d);  chk("idle_ctrl", d, 32'h0);
    chk("idle_timeout", {31'b0, timeout}, 32'h0);

    // LOAD=0 one-shot expires after one enabled cycle
    wr(32'h0, 32'h1);
    chk("l0_pre", {31'b0, timeout}, 32'h0);
    step(1);
    chk("l0_timeout", {31'b0, timeout}, 32'h1);
    rd(32'h0, d);  chk("l0_ctrl", d, 32'h0);

    // Decode edges
    wr(32'h4, 32'h0000_0033);
    sel  = 1'b0;
    we   = 1'b0;
    addr = 32'h4;
    #1;
    chk("sel0_rdata", rdata, 32'h0);
    addr = '0;
    wr(32'h8, 32'h55);
    rd(32'h8, d);  chk("value_wr_ignored", d, 32'h0);
    wr(32'h14, 32'h1234);
    rd(32'h4, d);  chk("alias_load", d, 32'h1234);
    rd(32'hF0000014, d);  chk("alias_load_rd", d, 32'h1234);
    wr(32'h0, 32'hFFFF_FFFE);
    rd(32'h0, d);  chk("ctrl_upper_zero", d, 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vsd_timer.md
Name: vsd_timer

Overview:
- Memory-mapped 32-bit down-counting timer peripheral on the simple SoC peripheral bus (sel/we/addr/wdata/rdata).
- Supports one-shot and periodic (auto-reload) modes.
- Exposes a sticky timeout flag both as a status register and as a level output usable as an interrupt line.

Parameters:
- WIDTH, 32, counter/LOAD/VALUE register width (bus data stays 32 bits; unused upper bits read 0).

Ports:
- clk  input  1  system clock, all state on rising edge.
- resetn  input  1  asynchronous active-low reset.
- sel  input  1  peripheral select; access valid only while high.
- we  input  1  1 = write, 0 = read (qualified by sel).
- addr  input  32  byte address; only addr[3:2] decoded, other bits ignored (aliasing allowed).
- wdata  input  32  write data.
- rdata  output  32  read data, combinational.
- timeout  output  1  sticky timeout flag (equals STATUS[0]).

Behaviour:
- Register map (addr[3:2]):
  - 0x00 CTRL RW: bit0 EN, bit1 MODE (0 one-shot, 1 periodic); other bits read 0.
  - 0x04 LOAD RW: reload value.
  - 0x08 VALUE RO: current count.
  - 0x0C STATUS: bit0 TIMEOUT, write-1-to-clear.
- Reset (async, resetn=0): CTRL=0, LOAD=0, VALUE=0, TIMEOUT=0; rdata=0 while sel=0; timeout=0.
- Write strobe: sel & we, captured at the rising clk edge.
- CTRL write:
  - Updates EN/MODE.
  - If wdata[0]=1: VALUE<=LOAD and TIMEOUT<=0 on the same edge (start/restart). Counting starts the following cycle.
  - If wdata[0]=0: counter halts, VALUE holds, TIMEOUT unchanged.
- LOAD write: updates LOAD only; VALUE changes at the next start or periodic reload.
- VALUE writes are ignored.
- STATUS write: wdata[0]=1 clears TIMEOUT; wdata[0]=0 has no effect.
- Counting: each edge with EN=1 and no CTRL write:
  - VALUE>1: VALUE<=VALUE-1.
  - VALUE<=1 (expiry): TIMEOUT<=1.
    - One-shot: VALUE<=0 and EN auto-clears to 0 (CTRL reads back with EN=0).
    - Periodic: VALUE<=LOAD, EN stays 1.
- Resulting sequences:
  - One-shot, LOAD=N: N, N-1, ..., 1, 0; TIMEOUT sets on the edge VALUE goes 1->0.
  - Periodic: N..1 repeating, period N cycles.
  - LOAD=0: expires on the first enabled cycle; in periodic, every cycle.
- Priorities, highest first: CTRL write > expiry/decrement. Expiry set beats a STATUS W1C in the same cycle.
- Reads: rdata = selected register when sel=1 & we=0, else 0. Purely combinational, zero-latency; bus samples rdata at the edge ending the access.
- timeout output is registered: asserted the cycle after expiry, held until W1C, restart, or reset.
- Arithmetic is unsigned; no wrap below 0.

Decomposition:
- Shared package vsd_timer_pkg:
  - register offsets ADDR_CTRL/ADDR_LOAD/ADDR_VALUE/ADDR_STATUS;
  - CTRL bit indices CTRL_EN=0, CTRL_MODE=1;
  - STATUS_TIMEOUT=0.
- One natural sub-module: vsd_timer_counter (VALUE register, decrement/reload/expiry logic; inputs start, en, mode, load; outputs value, expire).
- Register decode and read mux stay in the top.

Test Plan:
- One-shot: LOAD=10, CTRL=0x1 -> VALUE reads 10..1 then 0 and stays 0; STATUS=0x1; timeout=1; CTRL reads 0x0.
- Periodic: LOAD=5, CTRL=0x3 -> VALUE cycles 5,4,3,2,1,5,...; TIMEOUT set after first expiry; CTRL stays 0x3; a new CTRL start first clears TIMEOUT.
- W1C: after timeout, write STATUS=0x1 -> timeout=0 next cycle. Write STATUS=0x0 -> no change. W1C coinciding with a periodic expiry -> TIMEOUT stays 1.
- Pause: counting with LOAD=20, write CTRL=0x0 at VALUE=12 -> VALUE holds 12. Write LOAD=7, then CTRL=0x1 -> VALUE=7 and counts down.
- Reset mid-count: drop resetn at VALUE=6 -> all registers 0, timeout=0 immediately (async). After release, timer stays idle.
- Edge/decode: LOAD=0 one-shot -> timeout after 1 cycle. Read with sel=0 -> rdata=0. Write to 0x08 ignored. addr 0x14 aliases LOAD.
